// File: rtl/core_bus_arbiter_pkg.sv
// core_bus_arbiter_pkg: shared bus widths, hold-flag and select encodings
package core_bus_arbiter_pkg;
    localparam int BusAddrW = 32;
    localparam int BusDataW = 32;
    localparam logic [2:0] HoldNone = 3'd0;
    localparam logic [2:0] HoldPc   = 3'd1;
    localparam logic [2:0] HoldIf   = 3'd2;
    localparam logic [2:0] HoldId   = 3'd3;
    localparam logic SelectAsMaster = 1'b1;
    localparam logic SelectAsSlave  = 1'b0;
endpackage

// File: rtl/core_arb_pick.sv
// core_arb_pick: fixed-priority winner picker (M2 > M1 > M0, M0 beats M1 when starved)
// Ports: req[2:0] requests, starve = M0 starvation limit reached, win[2:0] one-hot winner
module core_arb_pick (
    input  logic [2:0] req,
    input  logic       starve,
    output logic [2:0] win
);
    always_comb begin
        win[2] = req[2];
        win[1] = !req[2] && req[1] && !(starve && req[0]);
        win[0] = !req[2] && req[0] && !win[1];
    end
endmodule

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: three-master single-slave bus arbiter with starvation guard and ack timeout
// Ports: clk, rst (async active-low); mN_* master request/response per master 0..2;
//        s_* shared slave side; select_as_o one-hot owner; hold_flag_o pipeline hold to core_ctrl
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req_i,
    input  logic                m1_req_i,
    input  logic                m2_req_i,
    input  logic [BusAddrW-1:0] m0_addr_i,
    input  logic [BusAddrW-1:0] m1_addr_i,
    input  logic [BusAddrW-1:0] m2_addr_i,
    input  logic [BusDataW-1:0] m0_wdata_i,
    input  logic [BusDataW-1:0] m1_wdata_i,
    input  logic [BusDataW-1:0] m2_wdata_i,
    input  logic                m0_we_i,
    input  logic                m1_we_i,
    input  logic                m2_we_i,
    output logic                m0_ack_o,
    output logic                m1_ack_o,
    output logic                m2_ack_o,
    output logic                m0_err_o,
    output logic                m1_err_o,
    output logic                m2_err_o,
    output logic [BusDataW-1:0] m0_rdata_o,
    output logic [BusDataW-1:0] m1_rdata_o,
    output logic [BusDataW-1:0] m2_rdata_o,
    output logic [2:0]          select_as_o,
    output logic                s_req_o,
    output logic [BusAddrW-1:0] s_addr_o,
    output logic [BusDataW-1:0] s_wdata_o,
    output logic                s_we_o,
    input  logic                s_ack_i,
    input  logic [BusDataW-1:0] s_rdata_i,
    output logic [2:0]          hold_flag_o
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [1:0] M0 = 2'd0, M1 = 2'd1, M2 = 2'd2;
    state_t     state;
    logic [1:0] owner;
    logic [7:0] starve, tcnt;
    logic [2:0] req, win, own_oh;
    logic       busy, own_req, act, tmo, ack, err, rd_ok;
    assign req = {m2_req_i, m1_req_i, m0_req_i};
    core_arb_pick u_pick (
        .req   (req),
        .starve(starve == 8'(STARVE_MAX)),
        .win   (win)
    );
    always_comb begin
        busy        = state == BUSY;
        own_oh      = 3'b001 << owner;
        own_req     = |(req & own_oh);
        // a dropped request ends the transaction silently
        act         = busy && own_req;
        tmo         = tcnt == 8'(TIMEOUT - 1);
        ack         = act && (s_ack_i || tmo);
        err         = act && !s_ack_i && tmo;
        rd_ok       = act && s_ack_i;
        m0_ack_o    = ack && owner == M0;
        m1_ack_o    = ack && owner == M1;
        m2_ack_o    = ack && owner == M2;
        m0_err_o    = err && owner == M0;
        m1_err_o    = err && owner == M1;
        m2_err_o    = err && owner == M2;
        m0_rdata_o  = (rd_ok && owner == M0) ? s_rdata_i : '0;
        m1_rdata_o  = (rd_ok && owner == M1) ? s_rdata_i : '0;
        m2_rdata_o  = (rd_ok && owner == M2) ? s_rdata_i : '0;
        s_req_o     = act;
        s_addr_o    = !act ? '0 : owner == M2 ? m2_addr_i : owner == M1 ? m1_addr_i : m0_addr_i;
        s_wdata_o   = !act ? '0 : owner == M2 ? m2_wdata_i : owner == M1 ? m1_wdata_i : m0_wdata_i;
        s_we_o      = act && (owner == M2 ? m2_we_i : owner == M1 ? m1_we_i : m0_we_i);
        select_as_o = busy ? own_oh : {3{SelectAsSlave}};
        // gated by rst so the hold request is silent while in reset
        hold_flag_o = (rst && m0_req_i && !m0_ack_o) ? HoldPc : HoldNone;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            owner  <= M0;
            starve <= '0;
            tcnt   <= '0;
        end else begin
            if (!m0_req_i) starve <= '0;
            if (state == IDLE) begin
                if (|req) begin
                    state  <= BUSY;
                    owner  <= win[2] ? M2 : win[1] ? M1 : M0;
                    tcnt   <= '0;
                    starve <= (win[0] || !m0_req_i) ? '0 :
                              (win[1] && starve != 8'(STARVE_MAX)) ? starve + 8'd1 : starve;
                end
            end else if (!own_req || ack) begin
                state <= IDLE;
            end else begin
                tcnt <= tcnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: table-driven and sequence checks with an ack scoreboard
module tb_core_bus_arbiter;
    import core_bus_arbiter_pkg::*;
    localparam int TO = 16;
    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        int          dly;
        logic [31:0] rdata;
    } vec_t;
    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req;
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [2:0]  we;
    logic        s_ack;
    logic [31:0] s_rdata;
    logic [2:0]  ack, err, sel, hold;
    logic [31:0] rd [3];
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [173:0] allout;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    vec_t        vecs[6];

    core_bus_arbiter #(.TIMEOUT(TO), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(req[0]), .m1_req_i(req[1]), .m2_req_i(req[2]),
        .m0_addr_i(addr[0]), .m1_addr_i(addr[1]), .m2_addr_i(addr[2]),
        .m0_wdata_i(wdata[0]), .m1_wdata_i(wdata[1]), .m2_wdata_i(wdata[2]),
        .m0_we_i(we[0]), .m1_we_i(we[1]), .m2_we_i(we[2]),
        .m0_ack_o(ack[0]), .m1_ack_o(ack[1]), .m2_ack_o(ack[2]),
        .m0_err_o(err[0]), .m1_err_o(err[1]), .m2_err_o(err[2]),
        .m0_rdata_o(rd[0]), .m1_rdata_o(rd[1]), .m2_rdata_o(rd[2]),
        .select_as_o(sel), .s_req_o(s_req), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_we_o(s_we), .s_ack_i(s_ack), .s_rdata_i(s_rdata), .hold_flag_o(hold)
    );

    assign allout = {ack, err, rd[0], rd[1], rd[2], sel, s_req, s_we, s_addr, s_wdata, hold};

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [191:0] a, logic [191:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, a, e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int n;
        n = ack == 3'b001 ? 0 : ack == 3'b010 ? 1 : ack == 3'b100 ? 2 : ack == 3'b000 ? -1 : 3;
        if (n >= 0) begin
            if (n == 3 || sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=%b, expected none", ack);
            end else begin
                e = sb.pop_front();
                check("ack_owner", 192'(n), 192'(e.m));
                check("ack_rdata", rd[n], e.rdata);
                check("ack_err", err[n], e.err);
            end
        end
        for (int i = 0; i < 3; i++)
            if (!ack[i]) check("nonack_zero", {err[i], rd[i]}, 0);
    end

    task automatic txn(vec_t v);
        exp_t e;
        logic done;
        done = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            addr[i]  = $urandom;
            wdata[i] = $urandom;
            we[i]    = 1'($urandom);
        end
        addr[v.m]  = v.addr;
        wdata[v.m] = v.wdata;
        we[v.m]    = v.we;
        req        = 3'b001 << v.m;
        s_ack      = 1'b0;
        s_rdata    = $urandom;
        @(negedge clk);
        check("idle_sreq", s_req, 0);
        check("idle_hold", hold, v.m == 0 ? HoldPc : HoldNone);
        for (int c = 1; c <= TO && !done; c++) begin
            tick;
            s_ack   = c == v.dly;
            s_rdata = s_ack ? v.rdata : $urandom;
            done    = s_ack || c == TO;
            if (done) begin
                e.m     = v.m;
                e.rdata = s_ack ? v.rdata : 32'h0;
                e.err   = !s_ack;
                sb.push_back(e);
            end
            @(negedge clk);
            check("bus_out", {s_req, s_we, s_addr, s_wdata}, {1'b1, v.we, v.addr, v.wdata});
            check("busy_sel", sel, 3'b001 << v.m);
            check("busy_hold", hold, (v.m == 0 && !done) ? HoldPc : HoldNone);
        end
        tick;
        req   = 3'b000;
        s_ack = 1'b0;
        @(negedge clk);
        check("ret_idle", {s_req, sel}, 0);
    endtask

    task automatic push(int m, logic [31:0] r);
        exp_t e;
        e.m     = m;
        e.rdata = r;
        e.err   = 1'b0;
        sb.push_back(e);
    endtask

    initial begin
        logic [2:0] prio_sel [6];
        int         starve_m [10];
        logic [2:0] a;
        vecs[0] = '{0, 32'h0000_0100, 32'h0000_0000, 1'b0, 2,  32'hDEAD_BEEF};
        vecs[1] = '{1, 32'h2000_0040, 32'hCAFE_F00D, 1'b1, 1,  32'h1234_5678};
        vecs[2] = '{2, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b1, 3,  32'h0BAD_F00D};
        vecs[3] = '{1, 32'h0000_8000, 32'h5555_AAAA, 1'b1, 0,  32'h0000_0055};
        vecs[4] = '{1, 32'h0000_8004, 32'h7777_0000, 1'b1, TO, 32'h0000_0077};
        vecs[5] = '{0, 32'h0000_0200, 32'h0000_0000, 1'b0, 15, 32'h8765_4321};
        prio_sel = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001};
        starve_m = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        req = 3'b000;
        we  = 3'b000;
        s_ack = 1'b0;
        s_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            addr[i]  = 32'h0;
            wdata[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        req = 3'b111;
        s_ack = 1'b1;
        s_rdata = 32'h9999_9999;
        #1 check("rst_outs", allout, 0);
        @(negedge clk) check("rst_outs_clk", allout, 0);
        tick;
        req = 3'b000;
        s_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk) check("post_rst", allout, 0);

        for (int i = 0; i < 6; i++) txn(vecs[i]);

        tick;
        req = 3'b111;
        s_ack = 1'b1;
        s_rdata = 32'h1111_2222;
        push(2, 32'h1111_2222);
        push(1, 32'h1111_2222);
        push(0, 32'h1111_2222);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("prio_sel", sel, prio_sel[c]);
            a = ack;
            tick;
            req = req & ~a;
        end
        check("prio_done", req, 0);
        s_ack = 1'b0;

        tick;
        req = 3'b011;
        s_ack = 1'b1;
        s_rdata = 32'h3333_4444;
        for (int g = 0; g < 10; g++) push(starve_m[g], 32'h3333_4444);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("starve_sel", sel, (c % 2 == 0) ? 3'b000 : 3'b001 << starve_m[c / 2]);
        end
        tick;
        req = 3'b000;
        s_ack = 1'b0;
        @(negedge clk) check("starve_idle", {s_req, sel}, 0);

        tick;
        req = 3'b010;
        addr[1] = 32'h0000_0ABC;
        s_ack = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            tick;
            if (c == 3) req = 3'b000;
            @(negedge clk);
            check("abort_sreq", s_req, c < 3);
            check("abort_sel", sel, 3'b010);
        end
        tick;
        @(negedge clk) check("abort_idle", sel, 0);

        tick;
        req = 3'b001;
        s_ack = 1'b0;
        @(negedge clk);
        tick;
        @(negedge clk) check("pre_rst_sel", sel, 3'b001);
        tick;
        rst = 1'b0;
        req = 3'b101;
        s_ack = 1'b1;
        #1 check("midbusy_rst", allout, 0);
        @(negedge clk) check("midbusy_rst_clk", allout, 0);
        tick;
        req = 3'b100;
        s_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk) check("rel_idle", {s_req, sel}, 0);
        tick;
        s_ack = 1'b1;
        s_rdata = 32'h4444_5555;
        push(2, 32'h4444_5555);
        @(negedge clk) check("rel_grant", {s_req, sel}, {1'b1, 3'b100});
        tick;
        req = 3'b000;
        s_ack = 1'b0;
        @(negedge clk) check("final_idle", {s_req, sel}, 0);

        check("sb_empty", 192'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_bus_arbiter.md
CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: slave-ack timeout in cycles, range 2..255.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive M1 grants allowed while M0 waits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports m0_req_i/m1_req_i/m2_req_i  input  1 each  requests (M0 = core fetch, M1 = core load/store, M2 = debug).
REQ-006 SHALL have ports mN_addr_i  input  32, mN_wdata_i  input  32, mN_we_i  input  1, per master N = 0..2.
REQ-007 SHALL have ports mN_ack_o  output  1, mN_err_o  output  1, mN_rdata_o  output  32, per master.
REQ-008 SHALL have port select_as_o  output  3  one-hot ownership; bit N = SelectAsMaster when master N owns the bus, else SelectAsSlave.
REQ-009 SHALL have ports s_req_o  output  1, s_addr_o  output  32, s_wdata_o  output  32, s_we_o  output  1  shared slave side.
REQ-010 SHALL have ports s_ack_i  input  1, s_rdata_i  input  32  slave response.
REQ-011 SHALL have port hold_flag_o  output  3  pipeline hold request to core_ctrl (HoldFlagBus encoding).

Function
REQ-012 SHALL implement FSM with states IDLE and BUSY; owner register is 2 bits (M0/M1/M2).
REQ-013 IDLE: when any req is high, owner latches winner, state goes to BUSY next cycle; no req means stay IDLE.
REQ-014 Winner priority SHALL be M2 > M1 > M0, except M0 wins over M1 when the starve counter equals STARVE_MAX.
REQ-015 Starve counter SHALL increment on each M1 grant taken while m0_req_i is high, clear on any M0 grant or when m0_req_i is low, and saturate at STARVE_MAX.
REQ-016 BUSY: s_req_o is 1; s_addr_o, s_wdata_o and s_we_o SHALL mux from owner combinationally; in IDLE all s_* outputs are 0.
REQ-017 BUSY with s_ack_i = 1: owner's mN_ack_o = 1 and mN_rdata_o = s_rdata_i in the same cycle; state goes to IDLE next cycle.
REQ-018 Non-owner ack, err and rdata SHALL be 0 at all times.
REQ-019 Arbitration latency SHALL be exactly 1 cycle (req seen in IDLE leads to s_req_o in the next cycle); min 2 cycles per transaction; back-to-back grants are separated by one IDLE cycle.
REQ-020 Timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack; when it reaches TIMEOUT-1 with no ack, owner gets ack = 1, err = 1, rdata = 0 that cycle, and state goes to IDLE.
REQ-021 Ack and timeout in the same cycle: ack wins, err = 0.
REQ-022 Owner deasserts req during BUSY: s_req_o drops that cycle, no ack is given, state goes to IDLE next cycle.
REQ-023 Requests from non-owners during BUSY SHALL be ignored until IDLE; they are not queued.
REQ-024 hold_flag_o SHALL be HoldPc when m0_req_i = 1 and M0 is not receiving ack this cycle; otherwise HoldNone; combinational.
REQ-025 select_as_o SHALL be 3'b000 in IDLE and the owner's one-hot bit in BUSY.

Reset
REQ-026 While rst = 0: state IDLE, owner M0, both counters 0, and all outputs 0 (hold_flag_o = HoldNone), regardless of inputs.
REQ-027 Reset asserted mid-BUSY SHALL abort the transaction without ack; the first grant after release follows REQ-013.

Structure
REQ-028 Hold encodings (HoldNone, HoldPc, HoldIf, HoldId), SelectAsMaster/SelectAsSlave, and bus widths SHALL live in the shared defines file; owner and state encodings stay local.
REQ-029 SHALL be a single module; a priority picker sub-module core_arb_pick (reqs + starve flag in, winner out) is permitted.

Verification
REQ-030 Single request: m0 req, addr 0x100, slave acks on the 2nd BUSY cycle with 0xDEADBEEF -> m0_ack_o pulses once with rdata 0xDEADBEEF, select_as_o = 001 during BUSY, hold_flag_o = HoldPc until the ack cycle.
REQ-031 Simultaneous requests: m0, m1 and m2 all request in one cycle, slave acks immediately -> grant order M2, M1, M0 with one IDLE cycle between grants.
REQ-032 Starvation: m0 and m1 held high continuously, immediate acks -> exactly 4 M1 grants, then 1 M0 grant, then the pattern repeats.
REQ-033 Timeout: m1 write, s_ack_i held 0 -> on BUSY cycle 16 m1_ack_o = 1, m1_err_o = 1, rdata = 0, then IDLE; same test with ack arriving on cycle 16 -> err = 0.
REQ-034 Abort: m1 drops req on its 3rd BUSY cycle -> s_req_o falls that cycle, no m1_ack_o, IDLE next cycle.
REQ-035 Reset: rst pulled low mid-BUSY -> all outputs 0 immediately; after release with m2 requesting -> M2 is granted 1 cycle later.
